window_placer: RTL and testbench

- Inverse of the crop stage: takes a compact cropped pixel stream and re-embeds it into a full-resolution frame at window [START_X,END_X)x[START_Y,END_Y).
- Everything outside the window is black.
- Generates its own output frame timing from free-running counters and buffers input pixels in a FIFO.
- Sits between the crop/scale stages and the display/HDMI output path; single clock domain (clk).

---
 rtl/window_placer_pkg.sv | 20 ++
 rtl/window_placer_fifo.sv | 57 +++++
 rtl/window_placer.sv | 184 ++++++++++++++++++
 tb/tb_window_placer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_placer_pkg.sv
// window_placer_pkg
//   Shared definitions for the window placer: default 720p timing constants,
//   the placement FSM state type and the black pixel value.
package window_placer_pkg;

    localparam int DEF_H_DISP   = 1280;
    localparam int DEF_V_DISP   = 720;
    localparam int DEF_H_TOTAL  = 1650;
    localparam int DEF_V_TOTAL  = 750;
    localparam int DEF_VS_LINES = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [23:0] BLACK = 24'h0;

endpackage

// File: rtl/window_placer_fifo.sv
// pixel_fifo
//   Synchronous show-ahead FIFO, depth 2^AW, DW bits wide.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     flush           empties the FIFO; wins over a same-cycle write
//     wr_en, wr_data  write request / data (accepted when not full, or when
//                     a pop happens in the same cycle)
//     rd_en           pop the head entry (ignored when empty)
//     rd_data         current head entry (valid while !empty)
//     full, empty     occupancy status
module pixel_fifo #(
    parameter int AW = 11,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_rd;
    logic          do_wr;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write while full is taken.
    assign do_wr   = wr_en && (!full || do_rd) && !flush;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/window_placer.sv
// window_placer
//   Re-embeds a compact cropped pixel stream into a full-resolution frame at
//   window [START_X,END_X) x [START_Y,END_Y); everything else is black.
//   Output timing comes from free-running counters; input pixels are buffered
//   in a show-ahead FIFO. EN=0 gives a registered bypass of the input stream.
//   Ports:
//     clk, rst_n                 pixel clock, async active-low reset
//     EN                         1 = place mode, 0 = bypass
//     clr_err                    clears the sticky flags (wins over set)
//     START_X/END_X, START_Y/END_Y  window, start inclusive / end exclusive,
//                                latched at output frame start
//     pre_vs, pre_de, pre_data   input stream (rising pre_vs = new frame)
//     post_vs, post_de, post_data  output stream, 1 clk after counters
//     overflow, underflow        sticky FIFO error flags
module window_placer
    import window_placer_pkg::*;
#(
    parameter int H_DISP   = DEF_H_DISP,
    parameter int V_DISP   = DEF_V_DISP,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int X_WIDTH  = 11,
    parameter int Y_WIDTH  = 11,
    parameter int FIFO_AW  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EN,
    input  logic               clr_err,
    input  logic [X_WIDTH-1:0] START_X,
    input  logic [Y_WIDTH-1:0] START_Y,
    input  logic [X_WIDTH-1:0] END_X,
    input  logic [Y_WIDTH-1:0] END_Y,
    input  logic               pre_vs,
    input  logic               pre_de,
    input  logic [23:0]        pre_data,
    output logic               post_vs,
    output logic               post_de,
    output logic [23:0]        post_data,
    output logic               overflow,
    output logic               underflow
);

    logic [X_WIDTH-1:0] h_cnt;
    logic [Y_WIDTH-1:0] v_cnt;
    logic [X_WIDTH-1:0] sh_start_x, sh_end_x;
    logic [Y_WIDTH-1:0] sh_start_y, sh_end_y;
    logic [X_WIDTH-1:0] win_x0, win_x1;
    logic [Y_WIDTH-1:0] win_y0, win_y1;
    state_t             state;
    logic               seen_vs;
    logic               pre_vs_d;
    logic               vs_rise;
    logic               active, vs_int, fs, in_win;
    logic               wr_req, pop, flush;
    logic               fifo_full, fifo_empty;
    logic [23:0]        fifo_head;

    // Free-running output timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == X_WIDTH'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == Y_WIDTH'(V_TOTAL - 1)) v_cnt <= '0;
            else                                v_cnt <= v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (h_cnt < X_WIDTH'(H_DISP)) && (v_cnt < Y_WIDTH'(V_DISP));
    assign vs_int = (v_cnt >= Y_WIDTH'(V_DISP)) && (v_cnt < Y_WIDTH'(V_DISP + VS_LINES));
    assign fs     = (h_cnt == '0) && (v_cnt == '0);

    // Shadow window; on the fs cycle itself the new values are already used
    // so pixel (0,0) sees the same window as the rest of its frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start_x <= '0;
            sh_end_x   <= '0;
            sh_start_y <= '0;
            sh_end_y   <= '0;
        end else if (fs) begin
            sh_start_x <= START_X;
            sh_end_x   <= END_X;
            sh_start_y <= START_Y;
            sh_end_y   <= END_Y;
        end
    end

    assign win_x0 = fs ? START_X : sh_start_x;
    assign win_x1 = fs ? END_X   : sh_end_x;
    assign win_y0 = fs ? START_Y : sh_start_y;
    assign win_y1 = fs ? END_Y   : sh_end_y;

    // START >= END on an axis can never satisfy both bounds: empty window.
    assign in_win = active && (h_cnt >= win_x0) && (h_cnt < win_x1)
                           && (v_cnt >= win_y0) && (v_cnt < win_y1);

    // Input frame sync edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_vs_d <= 1'b0;
        else        pre_vs_d <= pre_vs;
    end
    assign vs_rise = pre_vs && !pre_vs_d;

    // Placement FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            seen_vs <= 1'b0;
        end else if (!EN) begin
            state   <= IDLE;
            seen_vs <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= SYNC;
                    seen_vs <= 1'b0;
                end
                SYNC: begin
                    if (vs_rise) seen_vs <= 1'b1;
                    if (fs && seen_vs) state <= RUN;
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_req = pre_de && (state != IDLE);
    assign pop    = (state == RUN) && in_win && !fifo_empty;
    assign flush  = (state == IDLE) || ((state == SYNC) && vs_rise);

    pixel_fifo #(
        .AW (FIFO_AW),
        .DW (24)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_req),
        .wr_data (pre_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && fifo_full && !pop)                 overflow  <= 1'b1;
            if ((state == RUN) && in_win && fifo_empty)      underflow <= 1'b1;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= BLACK;
        end else if (!EN) begin
            post_vs   <= pre_vs;
            post_de   <= pre_de;
            post_data <= pre_data;
        end else begin
            post_vs   <= vs_int;
            post_de   <= active;
            post_data <= pop ? fifo_head : BLACK;
        end
    end

endmodule

// File: tb/tb_window_placer.sv
module tb_window_placer;

    localparam int HD = 16;
    localparam int VD = 8;
    localparam int HT = 20;
    localparam int VT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN = 1'b0;
    logic        clr_err = 1'b0;
    logic [10:0] START_X = '0, END_X = '0;
    logic [10:0] START_Y = '0, END_Y = '0;
    logic        pre_vs = 1'b0, pre_de = 1'b0;
    logic [23:0] pre_data = '0;
    logic        post_vs, post_de;
    logic [23:0] post_data;
    logic        overflow, underflow;

    window_placer #(
        .H_DISP   (HD),
        .V_DISP   (VD),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .VS_LINES (1),
        .X_WIDTH  (11),
        .Y_WIDTH  (11),
        .FIFO_AW  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .clr_err   (clr_err),
        .START_X   (START_X),
        .START_Y   (START_Y),
        .END_X     (END_X),
        .END_Y     (END_Y),
        .pre_vs    (pre_vs),
        .pre_de    (pre_de),
        .pre_data  (pre_data),
        .post_vs   (post_vs),
        .post_de   (post_de),
        .post_data (post_data),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bench-side raster position: bh/bv = position the DUT uses at the next
    // edge, ph/pv = position used at the most recent edge.
    int bh, bv, ph, pv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bh <= 0; bv <= 0; ph <= 0; pv <= 0;
        end else begin
            ph <= bh;
            pv <= bv;
            if (bh == HT - 1) begin
                bh <= 0;
                bv <= (bv == VT - 1) ? 0 : bv + 1;
            end else begin
                bh <= bh + 1;
            end
        end
    end

    typedef struct {
        logic        vs;
        logic        de;
        logic [23:0] data;
        int          h;
        int          v;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        in_vs;
        logic        in_de;
        logic [23:0] in_data;
        logic        ex_vs;
        logic        ex_de;
        logic [23:0] ex_data;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int h, input int v, input int x0, input int x1,
                                            input int y0, input int y1, input int n, input int base);
        int k;
        if (h < HD && v < VD && x0 < x1 && y0 < y1 &&
            h >= x0 && h < x1 && v >= y0 && v < y1) begin
            k = (v - y0) * (x1 - x0) + (h - x0);
            if (k < n) return 24'(base + k);
        end
        return 24'h0;
    endfunction

    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 4 * HT * VT && !got; i++) begin
            @(negedge clk);
            if (bh == 0 && bv == 0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_fs: got timeout expected frame start");
        end
    endtask

    task automatic frame_check(input int x0, input int x1, input int y0, input int y1,
                               input int n, input int base, input int cycles, input bit chg);
        exp_t e;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            e.h    = ph;
            e.v    = pv;
            e.de   = (ph < HD) && (pv < VD);
            e.vs   = (pv == VD);
            e.data = exp_pix(ph, pv, x0, x1, y0, y1, n, base);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("pix_h%0d_v%0d", e.h, e.v),
                  {6'b0, post_vs, post_de, post_data}, {6'b0, e.vs, e.de, e.data});
            if (chg && e.h == 0 && e.v == 3) END_X = 11'd12;
        end
    endtask

    // Align just after a frame start, arm place mode, pulse pre_vs and
    // pre-buffer npix pixels with values base, base+1, ...
    task automatic load(input int x0, input int x1, input int y0, input int y1,
                        input int npix, input int base);
        wait_fs();
        @(negedge clk);
        START_X = 11'(x0); END_X = 11'(x1);
        START_Y = 11'(y0); END_Y = 11'(y1);
        EN = 1'b1;
        @(negedge clk);
        pre_vs = 1'b1;
        @(negedge clk);
        pre_vs = 1'b0;
        for (int i = 0; i < npix; i++) begin
            pre_de = 1'b1;
            pre_data = 24'(base + i);
            @(negedge clk);
        end
        pre_de = 1'b0;
        pre_data = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b1, 24'hABCDEF};
        vecs[1] = '{1'b1, 1'b1, 24'h123456, 1'b1, 1'b1, 24'h123456};
        vecs[2] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF};
        vecs[4] = '{1'b1, 1'b1, 24'hA5A5A5, 1'b1, 1'b1, 24'hA5A5A5};
        vecs[5] = '{1'b0, 1'b1, 24'h0F0F0F, 1'b0, 1'b1, 24'h0F0F0F};

        // Reset state
        #12;
        check("rst_post_vs", {31'b0, post_vs}, 32'd0);
        check("rst_post_de", {31'b0, post_de}, 32'd0);
        check("rst_post_data", {8'b0, post_data}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_underflow", {31'b0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass vectors
        for (int i = 0; i < 6; i++) begin
            pre_vs = vecs[i].in_vs;
            pre_de = vecs[i].in_de;
            pre_data = vecs[i].in_data;
            e.vs = vecs[i].ex_vs; e.de = vecs[i].ex_de; e.data = vecs[i].ex_data;
            e.h = i; e.v = 0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("bypass_%0d", e.h),
                  {6'b0, post_vs, post_de, post_data}, {6'b0, e.vs, e.de, e.data});
        end
        pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;

        // Placement: 8 pixels into X 4..8, Y 2..4
        load(4, 8, 2, 4, 8, 1);
        wait_fs();
        frame_check(4, 8, 2, 4, 8, 1, HT * VT, 1'b0);
        check("place_overflow", {31'b0, overflow}, 32'd0);
        check("place_underflow", {31'b0, underflow}, 32'd0);
        EN = 1'b0;

        // Underflow: only 6 pixels
        load(4, 8, 2, 4, 6, 1);
        wait_fs();
        frame_check(4, 8, 2, 4, 6, 1, HT * VT, 1'b0);
        check("uf_set", {31'b0, underflow}, 32'd1);
        EN = 1'b0;
        @(negedge clk);
        check("uf_sticky_en0", {31'b0, underflow}, 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("uf_cleared", {31'b0, underflow}, 32'd0);

        // Shadow latch: END_X 8->12 at line 3 applies to the next frame
        load(4, 8, 2, 4, 24, 1);
        wait_fs();
        frame_check(4, 8, 2, 4, 8, 1, HT * VT, 1'b1);
        frame_check(4, 12, 2, 4, 16, 9, HT * VT, 1'b0);
        check("shadow_overflow", {31'b0, overflow}, 32'd0);
        check("shadow_underflow", {31'b0, underflow}, 32'd0);
        EN = 1'b0;

        // Overflow: 33 writes in SYNC, only 32 kept
        load(0, 16, 2, 5, 33, 1);
        check("of_set", {31'b0, overflow}, 32'd1);
        wait_fs();
        frame_check(0, 16, 2, 5, 32, 1, HT * VT, 1'b0);
        check("of_sticky", {31'b0, overflow}, 32'd1);
        check("of_then_uf", {31'b0, underflow}, 32'd1);

        // Reset mid-frame while in RUN
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_post_vs", {31'b0, post_vs}, 32'd0);
        check("midrst_post_de", {31'b0, post_de}, 32'd0);
        check("midrst_post_data", {8'b0, post_data}, 32'd0);
        check("midrst_overflow", {31'b0, overflow}, 32'd0);
        check("midrst_underflow", {31'b0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_check(0, 16, 2, 5, 0, 1, HT + 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
